pio_irq_in_multi: RTL
=====================

Name: pio_irq_in_multi

Overview:
- Parametrised Avalon-MM interrupt input port for the SM_MCU system. Successor to the fixed 2-bit rising/falling capture port.
- Synchronises WIDTH asynchronous inputs (VS/HS/TFT status lines) and debounces each bit with its own counter.
- Detects rising and/or falling edges per bit, latches them in a write-1-to-clear capture register, and raises a masked level IRQ to the Nios II.

Parameters:
- WIDTH, 8: number of input bits (1..32).
- SYNC_STAGES, 2: synchroniser flop depth (2..4).
- DBW, 8: debounce counter and DEBOUNCE register width.
- RISE_RST, all-ones: reset value of RISE_EN.
- FALL_RST, 0: reset value of FALL_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous input pins.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt request.

Behaviour:
- Clock and reset: clock clk; reset reset_n, asynchronous, active-low. All registers are clocked by clk and cleared by reset_n.
- Reset values:
  - readdata = 0, irq = 0, IRQ_MASK = 0, EDGE_CAPTURE = 0, DEBOUNCE = 0.
  - RISE_EN = RISE_RST, FALL_EN = FALL_RST.
  - Synchroniser flops, debounced value db and all counters = 0.
- Register map (wr = chipselect & ~write_n; bits above WIDTH/DBW read 0, ignored on write):
  - 0 DATA: RO, db.
  - 1 RISE_EN: RW.
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAPTURE: R/W1C.
  - 4 FALL_EN: RW.
  - 5 DEBOUNCE: RW, DBW bits.
  - 6 PENDING: RO, EDGE_CAPTURE & IRQ_MASK.
  - 7: reads 0.
- Read: readdata is registered from address every cycle regardless of chipselect, giving 1-cycle read latency and no wait states.
- Synchroniser: s = in_port delayed through SYNC_STAGES flops.
- Debounce, per bit i, with counter cnt[i] of DBW bits:
  - If s[i] == db[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE: db[i] <= s[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - DEBOUNCE = 0 toggles db on the first differing cycle.
  - A pulse on s shorter than DEBOUNCE+1 cycles is rejected and db is unchanged.
- Latency: a clean in_port step reaches db after SYNC_STAGES + 1 + DEBOUNCE clocks.
- Debounce boundary cases:
  - DEBOUNCE is compared live. If it is lowered below a running count, cnt keeps incrementing until it wraps at 2^DBW, then matches. This is accepted behaviour; software sets DEBOUNCE before unmasking.
  - cnt never exceeds DEBOUNCE when DEBOUNCE is static.
- Edge detection:
  - rise[i] = db[i] toggling 0 to 1 this clock; fall[i] = db[i] toggling 1 to 0 this clock.
  - ev[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - EDGE_CAPTURE[i] sets on the same clock edge that db[i] toggles.
  - RISE_EN = FALL_EN = 1 gives any-edge detection; both 0 disables capture for that bit.
- Capture clear:
  - A write to address 3 with writedata[i] = 1 clears bit i.
  - If ev[i] occurs on the same clock as the clear, set wins (bit stays 1) so no event is lost.
  - Writing 0 bits has no effect.
- Enable changes: RISE_EN/FALL_EN changes affect only later toggles; already captured bits persist.
- IRQ: irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers. It deasserts the cycle after the clearing write or mask write.
- Reset mid-debounce: counters and db clear, so an input held high after reset produces a rising capture once debounced (when RISE_EN is set).

Decomposition:
- Package pio_irq_pkg holds:
  - address constants ADDR_DATA .. ADDR_PENDING;
  - the SYNC_STAGES legal range;
  - the default RISE_RST/FALL_RST values.
- Sub-module pio_debounce_bit (parameters SYNC_STAGES, DBW):
  - one synchroniser, counter and db flop;
  - outputs db, rise, fall;
  - instantiated WIDTH times in a generate loop.
- The top level holds the register file, capture logic, read mux and irq.

Test Plan:
- Reset check: reset, read all addresses -> RISE_EN = 0xFF, FALL_EN = 0, all other registers 0, irq = 0.
- Rising capture and W1C clear:
  - Set DEBOUNCE = 0 and IRQ_MASK = 0x01, step in_port[0] 0->1.
  - EDGE_CAPTURE = 0x01 and irq = 1 exactly 3 clocks after the step (SYNC_STAGES = 2).
  - Write 0x01 to address 3 -> irq = 0 the next cycle.
- Debounce filter:
  - Set DEBOUNCE = 4; drive 4-cycle high pulses on in_port[3] -> DATA and EDGE_CAPTURE stay 0.
  - Drive a 5-cycle high level -> DATA[3] = 1 at 2 + 1 + 4 = 7 clocks after the step.
- Falling and both-edge modes:
  - Set FALL_EN = 0x02, RISE_EN = 0; pulse in_port[1] -> capture only on the falling edge.
  - Set RISE_EN = FALL_EN = 0x02 -> capture on both edges.
- Clear/set collision: issue a W1C of bit 2 on the exact clock db[2] toggles -> EDGE_CAPTURE[2] remains 1.
- Masking and PENDING: capture 0x0C with IRQ_MASK = 0x04 -> PENDING = 0x04, irq = 1; write IRQ_MASK = 0 -> irq = 0 and EDGE_CAPTURE is still 0x0C.

Source files
------------

// File: rtl/pio_irq_pkg.sv
// Shared constants for the multi-bit interrupt input port.
// Register addresses, synchroniser depth limits and enable reset defaults.
package pio_irq_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;
    localparam logic [2:0] ADDR_PENDING  = 3'd6;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    localparam logic [31:0] RISE_RST_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] FALL_RST_DEF = 32'h0000_0000;

    // Out-of-range depths are pulled back into the legal window.
    function automatic int clamp_sync(input int n);
        if (n < SYNC_MIN) return SYNC_MIN;
        if (n > SYNC_MAX) return SYNC_MAX;
        return n;
    endfunction

endpackage

// File: rtl/pio_irq_in_multi_if.sv
// Avalon-MM slave bus bundle for the interrupt input port.
// The bus master drives the request side; the port returns data and irq.
interface pio_irq_in_multi_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, debounce counter and filtered level.
// rise/fall pulse on the same clock that the filtered level flips.
module pio_debounce_bit
    import pio_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DBW         = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_bit,
    input  logic [DBW-1:0] debounce,
    output logic           db,
    output logic           rise,
    output logic           fall
);

    localparam int NS = clamp_sync(SYNC_STAGES);

    logic [NS-1:0]  sync_q, sync_d;
    logic [DBW-1:0] cnt_q, cnt_d;
    logic           db_q, db_d;
    logic           s;
    logic           toggle;

    always_comb begin
        sync_d = {sync_q[NS-2:0], in_bit};
        s      = sync_q[NS-1];
        cnt_d  = cnt_q;
        db_d   = db_q;
        toggle = 1'b0;
        // The counter only runs while the synchronised input disagrees.
        if (s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == debounce) begin
            toggle = 1'b1;
            db_d   = s;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + DBW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db   = db_q;
    assign rise = toggle & s;
    assign fall = toggle & ~s;

endmodule

// File: rtl/pio_irq_in_multi.sv
// Parametrised interrupt input port: debounced inputs, per-bit edge
// selection, write-1-to-clear capture and a masked level irq.
module pio_irq_in_multi
    import pio_irq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               DBW         = 8,
    parameter logic [WIDTH-1:0] RISE_RST    = RISE_RST_DEF[WIDTH-1:0],
    parameter logic [WIDTH-1:0] FALL_RST    = FALL_RST_DEF[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    pio_irq_in_multi_if.slave bus
);

    logic [WIDTH-1:0] db, rise, fall, ev, clr;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [DBW-1:0]   deb_q, deb_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr;
    logic             wdata_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBW         (DBW)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .debounce (deb_q),
            .db       (db[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign wr           = bus.chipselect & ~bus.write_n;
    assign wdata_unused = ^bus.writedata;

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        deb_d     = deb_q;
        clr       = '0;
        if (wr) begin
            unique case (bus.address)
                ADDR_RISE_EN:  rise_en_d = bus.writedata[WIDTH-1:0];
                ADDR_IRQ_MASK: mask_d    = bus.writedata[WIDTH-1:0];
                ADDR_EDGE_CAP: clr       = bus.writedata[WIDTH-1:0];
                ADDR_FALL_EN:  fall_en_d = bus.writedata[WIDTH-1:0];
                ADDR_DEBOUNCE: deb_d     = bus.writedata[DBW-1:0];
                default: ;
            endcase
        end
        // A new event beats a simultaneous clear so nothing is lost.
        ev    = (rise & rise_en_q) | (fall & fall_en_q);
        cap_d = (cap_q & ~clr) | ev;
    end

    always_comb begin
        readdata_d = '0;
        unique case (bus.address)
            ADDR_DATA:     readdata_d = 32'(db);
            ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
            ADDR_IRQ_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE_CAP: readdata_d = 32'(cap_q);
            ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
            ADDR_DEBOUNCE: readdata_d = 32'(deb_q);
            ADDR_PENDING:  readdata_d = 32'(cap_q & mask_q);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q  <= RISE_RST;
            fall_en_q  <= FALL_RST;
            mask_q     <= '0;
            cap_q      <= '0;
            deb_q      <= '0;
            readdata_q <= '0;
        end else begin
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            deb_q      <= deb_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(cap_q & mask_q);

endmodule
